// File: rtl/csr.sv
// Machine-mode CSR file for the RV32I execute stage: combinational read, read-modify-write on clk.
// Optional 64-bit cycle counter (mcycle/mcycleh, cycle/cycleh aliases) enabled by CSR_COUNTERS_EN.
module csr #(
  parameter logic [31:0] HART_ID  = 32'd0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  CSRControl,
  input  logic [31:0] instr,
  input  logic [31:0] wd,
  output logic [31:0] rd
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [31:0] MIE_MASK       = 32'h0000_0888;

  logic [11:0] csrAddr;
  logic [4:0]  zimm;
  logic [31:0] src;
  logic [31:0] newVal;
  logic        opValid;
  logic        wrEn;
  logic        unusedInstr;

  assign csrAddr     = instr[31:20];
  assign zimm        = instr[19:15];
  assign unusedInstr = ^instr[14:0];

  logic        mstatusMie_q, mstatusMie_d;
  logic        mstatusMpie_q, mstatusMpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;

`ifdef CSR_COUNTERS_EN
  logic [63:0] cycle_q, cycle_d;
`endif

  // Bit 2 of CSRControl selects the zimm form; only 0001-0011 and 0101-0111 are real operations.
  assign opValid = (CSRControl[3] == 1'b0) && (CSRControl[1:0] != 2'b00);
  assign src     = CSRControl[2] ? {27'b0, zimm} : wd;
  assign wrEn    = opValid && ((CSRControl[1:0] == 2'b01) || (zimm != 5'd0))
                   && (csrAddr[11:10] != 2'b11);

  always_comb begin
    rd = 32'd0;
    case (csrAddr)
      ADDR_MSTATUS:  rd = {19'b0, 2'b11, 3'b0, mstatusMpie_q, 3'b0, mstatusMie_q, 3'b0};
      ADDR_MISA:     rd = MISA_VAL;
      ADDR_MIE:      rd = mie_q;
      ADDR_MTVEC:    rd = mtvec_q;
      ADDR_MSCRATCH: rd = mscratch_q;
      ADDR_MEPC:     rd = mepc_q;
      ADDR_MCAUSE:   rd = mcause_q;
      ADDR_MTVAL:    rd = mtval_q;
      ADDR_MHARTID:  rd = HART_ID;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE,  ADDR_CYCLE:  rd = cycle_q[31:0];
      ADDR_MCYCLEH, ADDR_CYCLEH: rd = cycle_q[63:32];
`endif
      default:       rd = 32'd0;
    endcase
  end

  always_comb begin
    case (CSRControl[1:0])
      2'b01:   newVal = src;
      2'b10:   newVal = rd | src;
      2'b11:   newVal = rd & ~src;
      default: newVal = rd;
    endcase
  end

  always_comb begin
    mstatusMie_d  = mstatusMie_q;
    mstatusMpie_d = mstatusMpie_q;
    mie_d         = mie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    if (wrEn) begin
      case (csrAddr)
        ADDR_MSTATUS: begin
          mstatusMie_d  = newVal[3];
          mstatusMpie_d = newVal[7];
        end
        ADDR_MIE:      mie_d      = newVal & MIE_MASK;
        ADDR_MTVEC:    mtvec_d    = {newVal[31:2], 2'b00};
        ADDR_MSCRATCH: mscratch_d = newVal;
        ADDR_MEPC:     mepc_d     = {newVal[31:2], 2'b00};
        ADDR_MCAUSE:   mcause_d   = newVal;
        ADDR_MTVAL:    mtval_d    = newVal;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatusMie_q  <= 1'b0;
      mstatusMpie_q <= 1'b0;
      mie_q         <= 32'd0;
      mtvec_q       <= 32'd0;
      mscratch_q    <= 32'd0;
      mepc_q        <= 32'd0;
      mcause_q      <= 32'd0;
      mtval_q       <= 32'd0;
    end else begin
      mstatusMie_q  <= mstatusMie_d;
      mstatusMpie_q <= mstatusMpie_d;
      mie_q         <= mie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  // A software write to either half replaces it and skips that cycle's increment.
  always_comb begin
    cycle_d = cycle_q + 64'd1;
    if (wrEn && (csrAddr == ADDR_MCYCLE)) begin
      cycle_d = {cycle_q[63:32], newVal};
    end else if (wrEn && (csrAddr == ADDR_MCYCLEH)) begin
      cycle_d = {newVal, cycle_q[31:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= 64'd0;
    end else begin
      cycle_q <= cycle_d;
    end
  end
`endif

endmodule

// File: tb/tb_csr.sv
// Directed self-checking bench for csr: reset values, RW/RS/RC forms, masking, read-only and counters.
module tb_csr;

  logic        clk;
  logic        rst_n;
  logic [3:0]  CSRControl;
  logic [31:0] instr;
  logic [31:0] wd;
  logic [31:0] rd;

  int checkCount = 0;
  int failCount  = 0;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_RW   = 4'b0001;
  localparam logic [3:0] OP_RS   = 4'b0010;
  localparam logic [3:0] OP_RC   = 4'b0011;
  localparam logic [3:0] OP_RWI  = 4'b0101;
  localparam logic [3:0] OP_RSI  = 4'b0110;
  localparam logic [3:0] OP_RCI  = 4'b0111;

  csr dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .CSRControl (CSRControl),
    .instr      (instr),
    .wd         (wd),
    .rd         (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change just after a falling edge so the next rising edge sees them settled.
  task automatic applyStimulus(input logic [3:0] ctl, input logic [11:0] addr,
                               input logic [4:0] rs1, input logic [31:0] data);
    CSRControl = ctl;
    instr      = {addr, rs1, 3'b001, 5'd1, 7'b1110011};
    wd         = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic doWrite(input logic [3:0] ctl, input logic [11:0] addr,
                         input logic [4:0] rs1, input logic [31:0] data);
    applyStimulus(ctl, addr, rs1, data);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(OP_NONE, addr, 5'd0, 32'd0);
  endtask

  task automatic readCheck(input string tag, input logic [11:0] addr, input logic [31:0] expected);
    applyStimulus(OP_NONE, addr, 5'd0, 32'd0);
    #1;
    checkOutput(tag, rd, expected);
  endtask

  initial begin
    rst_n = 1'b1;
    applyStimulus(OP_NONE, 12'h300, 5'd0, 32'd0);
    #3 rst_n = 1'b0;
    #1 checkOutput("mstatusInReset", rd, 32'h0000_1800);
    @(negedge clk);
    rst_n = 1'b1;

    readCheck("mstatusReset", 12'h300, 32'h0000_1800);
    readCheck("mscratchReset", 12'h340, 32'h0000_0000);

    applyStimulus(OP_RW, 12'h340, 5'd5, 32'hDEAD_BEEF);
    #1 checkOutput("rwOldValue", rd, 32'h0000_0000);
    @(posedge clk);
    @(negedge clk);
    readCheck("rwMscratch", 12'h340, 32'hDEAD_BEEF);

    doWrite(OP_RS, 12'h340, 5'd0, 32'hFFFF_FFFF);
    readCheck("rsZeroNoWrite", 12'h340, 32'hDEAD_BEEF);

    applyStimulus(OP_RCI, 12'h340, 5'h0F, 32'hFFFF_FFFF);
    #1 checkOutput("rciOldValue", rd, 32'hDEAD_BEEF);
    @(posedge clk);
    @(negedge clk);
    readCheck("rciMscratch", 12'h340, 32'hDEAD_BEE0);

    doWrite(OP_RS, 12'h340, 5'd3, 32'h0000_000F);
    readCheck("rsMscratch", 12'h340, 32'hDEAD_BEEF);

    doWrite(OP_RSI, 12'h342, 5'h10, 32'hFFFF_FFFF);
    readCheck("rsiMcause", 12'h342, 32'h0000_0010);
    doWrite(OP_RWI, 12'h342, 5'h1F, 32'hFFFF_FFFF);
    readCheck("rwiMcause", 12'h342, 32'h0000_001F);
    doWrite(OP_RW, 12'h342, 5'd2, 32'h8000_0003);
    readCheck("rwMcause", 12'h342, 32'h8000_0003);

    doWrite(OP_RW, 12'h341, 5'd2, 32'h0000_0013);
    readCheck("mepcMask", 12'h341, 32'h0000_0010);

    doWrite(OP_RW, 12'h300, 5'd2, 32'hFFFF_FFFF);
    readCheck("mstatusMask", 12'h300, 32'h0000_1888);
    doWrite(OP_RC, 12'h300, 5'd1, 32'h0000_0008);
    readCheck("mstatusClearMie", 12'h300, 32'h0000_1880);
    doWrite(OP_RWI, 12'h300, 5'd0, 32'hFFFF_FFFF);
    readCheck("mstatusRwiZero", 12'h300, 32'h0000_1800);

    doWrite(OP_RW, 12'h301, 5'd2, 32'h0000_0000);
    readCheck("misaReadOnly", 12'h301, 32'h4000_0100);

    doWrite(OP_RW, 12'h304, 5'd2, 32'hFFFF_FFFF);
    readCheck("mieMask", 12'h304, 32'h0000_0888);
    doWrite(OP_RW, 12'h305, 5'd2, 32'hFFFF_FFFF);
    readCheck("mtvecMask", 12'h305, 32'hFFFF_FFFC);
    doWrite(OP_RW, 12'h343, 5'd2, 32'h1234_5678);
    readCheck("mtval", 12'h343, 32'h1234_5678);
    doWrite(OP_RW, 12'h344, 5'd2, 32'hFFFF_FFFF);
    readCheck("mipZero", 12'h344, 32'h0000_0000);
    readCheck("mhartid", 12'hF14, 32'h0000_0000);
    readCheck("mvendorid", 12'hF11, 32'h0000_0000);

    doWrite(4'b0100, 12'h340, 5'd2, 32'h0000_0000);
    doWrite(4'b1001, 12'h340, 5'd2, 32'h0000_0000);
    readCheck("invalidCodes", 12'h340, 32'hDEAD_BEEF);

    applyStimulus(OP_RW, 12'h7C0, 5'd2, 32'h0000_1234);
    #1 checkOutput("unimplOld", rd, 32'h0000_0000);
    @(posedge clk);
    @(negedge clk);
    readCheck("unimplRead", 12'h7C0, 32'h0000_0000);

    // Reset held across a write edge must clear state immediately and block the write.
    applyStimulus(OP_RW, 12'h340, 5'd2, 32'h0000_0001);
    #2 rst_n = 1'b0;
    #1 checkOutput("asyncResetClear", rd, 32'h0000_0000);
    @(posedge clk);
    #1 checkOutput("resetBlocksWrite", rd, 32'h0000_0000);
    applyStimulus(OP_NONE, 12'h340, 5'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef CSR_COUNTERS_EN
    repeat (5) @(posedge clk);
    @(negedge clk);
    readCheck("mcycleCount", 12'hB00, 32'd5);
    doWrite(OP_RW, 12'hB00, 5'd2, 32'hFFFF_FFFF);
    readCheck("mcycleWritten", 12'hB00, 32'hFFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    readCheck("mcycleWrap", 12'hB00, 32'h0000_0000);
    readCheck("mcyclehCarry", 12'hB80, 32'h0000_0001);
    readCheck("cyclehAlias", 12'hC80, 32'h0000_0001);
`else
    repeat (5) @(posedge clk);
    @(negedge clk);
    readCheck("mcycleAbsent", 12'hB00, 32'h0000_0000);
    doWrite(OP_RW, 12'hB80, 5'd2, 32'h5555_5555);
    readCheck("mcyclehAbsent", 12'hB80, 32'h0000_0000);
    doWrite(OP_RW, 12'hC00, 5'd2, 32'hFFFF_FFFF);
    readCheck("cycleAbsent", 12'hC00, 32'h0000_0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
